// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response handshake and RAM port bundle for mem_access_unit
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_en;
  logic        ram_we;
  logic        ram_rst;
  logic [31:0] ram_addr;
  logic [31:0] ram_di;
  logic [31:0] ram_dout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_en, ram_we, ram_rst, ram_addr, ram_di
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_en, ram_we, ram_rst, ram_addr, ram_di
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for the single-port data RAM
// Sub-word stores are read-modify-write since the RAM has no byte enables.
module mem_access_unit (
  input logic             clk,
  input logic             rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LD_WAIT, RMW_WAIT, RMW_WR, RESP} state_t;

  state_t      state;
  logic [31:0] lat_addr;
  logic [2:0]  lat_funct3;
  logic [15:0] lat_wdata;
  logic [31:0] merged;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        legal;
  logic        aligned;
  logic        req_ok;
  logic        accept;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;
  logic [31:0] merge_word;

  always_comb begin
    legal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !bus.req_we;
      default:                legal = 1'b0;
    endcase
    aligned = 1'b1;
    case (bus.req_funct3[1:0])
      2'b01:   aligned = !bus.req_addr[0];
      2'b10:   aligned = (bus.req_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign req_ok = legal && aligned;
  assign accept = bus.req_valid && !rst && (state == IDLE);

  // The IDLE access is combinational so the RAM samples it on the accepting edge.
  always_comb begin
    bus.req_ready = !rst && (state == IDLE);
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = lat_addr;
    bus.ram_di    = merged;
    if (!rst) begin
      case (state)
        IDLE: begin
          bus.ram_addr = bus.req_addr;
          bus.ram_di   = bus.req_wdata;
          bus.ram_en   = bus.req_valid && req_ok;
          bus.ram_we   = bus.req_valid && req_ok && bus.req_we && (bus.req_funct3 == 3'b010);
        end
        RMW_WR: begin
          bus.ram_en = 1'b1;
          bus.ram_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_rst    = rst;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

  // Little-endian lane selection on the word returned by the RAM.
  always_comb begin
    case (lat_addr[1:0])
      2'b00:   sel_byte = bus.ram_dout[7:0];
      2'b01:   sel_byte = bus.ram_dout[15:8];
      2'b10:   sel_byte = bus.ram_dout[23:16];
      default: sel_byte = bus.ram_dout[31:24];
    endcase
    sel_half = lat_addr[1] ? bus.ram_dout[31:16] : bus.ram_dout[15:0];

    case (lat_funct3)
      3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_ext = {24'd0, sel_byte};
      3'b101:  load_ext = {16'd0, sel_half};
      default: load_ext = bus.ram_dout;
    endcase

    merge_word = bus.ram_dout;
    if (lat_funct3[1:0] == 2'b01) begin
      if (lat_addr[1]) merge_word[31:16] = lat_wdata;
      else             merge_word[15:0]  = lat_wdata;
    end else begin
      case (lat_addr[1:0])
        2'b00:   merge_word[7:0]   = lat_wdata[7:0];
        2'b01:   merge_word[15:8]  = lat_wdata[7:0];
        2'b10:   merge_word[23:16] = lat_wdata[7:0];
        default: merge_word[31:24] = lat_wdata[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_addr     <= 32'd0;
      lat_funct3   <= 3'd0;
      lat_wdata    <= 16'd0;
      merged       <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid_q <= 1'b0;
          if (accept) begin
            lat_addr   <= bus.req_addr;
            lat_funct3 <= bus.req_funct3;
            lat_wdata  <= bus.req_wdata[15:0];
            if (!req_ok) begin
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
              resp_valid_q <= 1'b1;
              state        <= RESP;
            end else if (!bus.req_we) begin
              state <= LD_WAIT;
            end else if (bus.req_funct3 == 3'b010) begin
              resp_err_q   <= 1'b0;
              resp_rdata_q <= 32'd0;
              resp_valid_q <= 1'b1;
              state        <= RESP;
            end else begin
              state <= RMW_WAIT;
            end
          end
        end
        LD_WAIT: begin
          resp_rdata_q <= load_ext;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RMW_WAIT: begin
          merged <= merge_word;
          state  <= RMW_WR;
        end
        RMW_WR: begin
          resp_rdata_q <= 32'd0;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          resp_valid_q <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit with a 1-cycle RAM model
module tb_mem_access_unit;

  logic clk;
  logic rst;
  logic preload;
  int   checks;
  int   errors;
  int   en_cnt;
  int   wr_cnt;
  int   resp_cnt;
  logic [31:0] mem [0:15];

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word RAM, read data one cycle after an enabled read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem[0] <= 32'h8899AABB;
    end else if (bus.ram_en && bus.ram_we) begin
      mem[bus.ram_addr[5:2]] <= bus.ram_di;
    end
    if (bus.ram_rst) bus.ram_dout <= 32'd0;
    else if (bus.ram_en && !bus.ram_we) bus.ram_dout <= mem[bus.ram_addr[5:2]];
  end

  always @(posedge clk) begin
    if (rst) begin
      en_cnt   <= 0;
      wr_cnt   <= 0;
      resp_cnt <= 0;
    end else begin
      if (bus.ram_en) en_cnt <= en_cnt + 1;
      if (bus.ram_en && bus.ram_we) wr_cnt <= wr_cnt + 1;
      if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge and check result, latency and RAM traffic.
  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_lat, input int exp_en, input int exp_wr);
    int n;
    int lat;
    int en0;
    int wr0;
    logic [31:0] rdata;
    logic err;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    en0 = en_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    lat   = 99;
    rdata = 32'hxxxxxxxx;
    err   = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        lat   = c;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
    end
    chk({tag, " rdata"}, rdata, exp_rdata);
    chk({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " ram_en count"}, 32'(en_cnt - en0), 32'(exp_en));
    chk({tag, " ram write count"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    @(negedge clk);
    chk({tag, " resp pulse width"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    int acc;
    int rsp;
    int en0;
    int r0;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    preload = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    @(negedge clk);
    @(negedge clk);
    chk("rst req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst ram_en", {31'd0, bus.ram_en}, 32'd0);
    chk("rst ram_we", {31'd0, bus.ram_we}, 32'd0);
    chk("rst ram_rst", {31'd0, bus.ram_rst}, 32'd1);
    chk("rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst resp_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'd0);
    rst = 1'b0;
    preload = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("post-rst req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("post-rst ram_rst", {31'd0, bus.ram_rst}, 32'd0);

    txn("lb@1",  1'b0, 3'b000, 32'h001, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1, 0);
    txn("lbu@1", 1'b0, 3'b100, 32'h001, 32'h0, 32'h000000AA, 1'b0, 2, 1, 0);
    txn("lb@3",  1'b0, 3'b000, 32'h003, 32'h0, 32'hFFFFFF88, 1'b0, 2, 1, 0);
    txn("lh@2",  1'b0, 3'b001, 32'h002, 32'h0, 32'hFFFF8899, 1'b0, 2, 1, 0);
    txn("lhu@2", 1'b0, 3'b101, 32'h002, 32'h0, 32'h00008899, 1'b0, 2, 1, 0);
    txn("lw@0",  1'b0, 3'b010, 32'h000, 32'h0, 32'h8899AABB, 1'b0, 2, 1, 0);

    txn("sw@4",  1'b1, 3'b010, 32'h004, 32'h12345678, 32'h0, 1'b0, 1, 1, 1);
    chk("sw mem", mem[1], 32'h12345678);
    txn("lw@4",  1'b0, 3'b010, 32'h004, 32'h0, 32'h12345678, 1'b0, 2, 1, 0);

    txn("sb@6",  1'b1, 3'b000, 32'h006, 32'hFFFFFFCD, 32'h0, 1'b0, 3, 2, 1);
    chk("sb mem", mem[1], 32'h12CD5678);
    txn("sh@4",  1'b1, 3'b001, 32'h004, 32'h1111BEEF, 32'h0, 1'b0, 3, 2, 1);
    chk("sh mem", mem[1], 32'h12CDBEEF);
    txn("lw@4b", 1'b0, 3'b010, 32'h004, 32'h0, 32'h12CDBEEF, 1'b0, 2, 1, 0);

    txn("lw@2 misaligned",  1'b0, 3'b010, 32'h002, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    txn("sh@3 misaligned",  1'b1, 3'b001, 32'h003, 32'hFFFF, 32'h0, 1'b1, 1, 0, 0);
    txn("load f3=011",      1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    txn("store f3=100",     1'b1, 3'b100, 32'h000, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    chk("error mem", mem[1], 32'h12CDBEEF);

    // Reset asserted while the sb is in its write cycle.
    r0 = resp_cnt;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h000;
    bus.req_wdata  = 32'h00000055;
    bus.req_valid  = 1'b1;
    chk("rmw-rst ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw-rst write strobe", {31'd0, bus.ram_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rmw-rst ram_en gated", {31'd0, bus.ram_en}, 32'd0);
    @(negedge clk);
    chk("rmw-rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rmw-rst ready after", {31'd0, bus.req_ready}, 32'd1);
    chk("rmw-rst mem", mem[0], 32'h8899AABB);
    chk("rmw-rst no resp", 32'(resp_cnt), 32'd0);
    chk("rmw-rst resp before", 32'(r0 >= 0), 32'd1);

    // Back-to-back loads with req_valid held high.
    acc = 0;
    rsp = 0;
    en0 = en_cnt;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h000;
    bus.req_valid  = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (bus.req_valid && bus.req_ready) acc++;
      if (bus.resp_valid) rsp++;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("b2b accepts", 32'(acc), 32'd3);
    chk("b2b responses", 32'(rsp), 32'd3);
    chk("b2b ram reads", 32'(en_cnt - en0), 32'd3);
    chk("b2b rdata", bus.resp_rdata, 32'h8899AABB);
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that drives the single-port data block RAM on behalf of the CPU memory stage. It accepts one request at a time over a valid/ready handshake and issues word reads and writes to the RAM port. It absorbs the RAM's one-cycle read latency and returns a registered, extended load result. Byte and halfword stores are done as read-modify-write, because the RAM has no byte enables.

## Interface
- No parameters. Data and address are fixed at 32 bits.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the low byte or low half is used for sub-word stores
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result (0 for stores and errors)
- resp_err  out  1  misaligned access or illegal funct3; valid with resp_valid
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_rst  out  1  RAM output-register reset; equal to rst
- ram_addr  out  32  byte address to RAM (RAM uses addr[31:2])
- ram_di  out  32  RAM write data
- ram_dout  in  32  RAM read data, valid the cycle after an enabled read

## Operation
- States: IDLE, LD_WAIT, RMW_WAIT, RMW_WR, RESP.
- req_ready = (state == IDLE). A request is accepted on the edge where req_valid && req_ready. All request fields are latched at that edge.
- RAM issue in IDLE is combinational from the request fields, so the RAM samples the access on the same edge that accepts it:
  - ram_addr = req_addr
  - ram_en = req_valid && legal && (load || store)
- Legal widths:
  - loads: 000, 001, 010, 100, 101
  - stores: 000, 001, 010
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
- An illegal or misaligned request issues no RAM access (ram_en=0). It goes IDLE→RESP with resp_err=1 and resp_rdata=0.
- Load: IDLE (read issued) → LD_WAIT → RESP.
  - In LD_WAIT, the lane is selected from ram_dout by the latched addr[1:0] (little-endian: offset 0 = bits 7:0).
  - The selected lane is sign-extended (b, h) or zero-extended (bu, hu, w) and registered into resp_rdata.
- sw: IDLE, with ram_en=1, ram_we=1, ram_di=req_wdata → RESP.
- sb/sh: IDLE (read issued) → RMW_WAIT → RMW_WR → RESP.
  - In RMW_WAIT, the selected byte or half lane of ram_dout is replaced with wdata[7:0] or wdata[15:0], and the merged word is registered.
  - In RMW_WR, drive ram_en=1, ram_we=1, ram_addr = latched addr, ram_di = merged word.
- RESP: resp_valid=1 for exactly one cycle, then → IDLE.
- ram_en=0 and ram_we=0 in every state/cycle not listed above.
- Addresses pass through unmodified. Wrap-around beyond RAM depth is the RAM's behaviour.

## Timing
- Acceptance edge = end of cycle k. resp_valid is high in:
  - cycle k+1 for sw and errors
  - cycle k+2 for loads
  - cycle k+3 for sb/sh
- resp_rdata and resp_err are registered and stable while resp_valid=1. They hold their values until the next RESP.
- No new request is accepted during RESP. The next acceptance is at the earliest in the cycle after RESP.
- Reset values: state IDLE; resp_valid, resp_err = 0; resp_rdata = 0; merged-word register = 0.
- While rst=1: ram_en=0, ram_we=0, req_ready=0, ram_rst=1.
- Reset mid-operation abandons the transaction. A reset during RMW_WR suppresses the write, and no response is produced.

## Test plan
- Preload word 0x000 = 0x8899AABB. Run lb @0x001 → resp_rdata 0xFFFFFFAA. Run lbu @0x001 → 0x000000AA. resp_valid must appear 2 cycles after acceptance.
- Run lh @0x002 on the same word → 0xFFFF8899. Run lhu → 0x00008899. Run lw @0x000 → 0x8899AABB.
- Run sw 0x12345678 @0x004 (resp 1 cycle after accept), then lw @0x004 → 0x12345678.
- Run sb 0x...CD @0x006 on word 0x12345678 → RAM word 0x12CD5678. Check one RAM write in RMW_WR and resp 3 cycles after accept. Run sh 0xBEEF @0x004 → 0x12CDBEEF.
- Run lw @0x002, sh @0x003, and load funct3=011. Each must give resp_err=1, resp_rdata=0, ram_en never asserted, resp 1 cycle after accept.
- Assert rst during RMW_WR of an sb. RAM word must be unchanged, no resp_valid, req_ready=1 on the first cycle after rst falls. Holding req_valid high back-to-back must accept exactly one request per completed transaction.
